// File: rtl/cal_key_engine.sv
// cal_key_engine: keypad-driven calculator core. Builds up to 4-digit BCD operands,
// evaluates chained add/subtract, converts results back to BCD for the 7-seg digits.
module cal_key_engine #(
    parameter int unsigned MAX_VAL     = 9999,
    parameter logic [31:0] ERROR_CODE  = 32'h00000ABB,
    parameter int unsigned CONV_CYCLES = 14
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       valid,
    input  logic [3:0] key,
    output logic [7:0] digit1,
    output logic [7:0] digit2,
    output logic [7:0] digit3,
    output logic [7:0] digit4,
    output logic       sign,
    output logic       busy
);

    typedef enum logic [2:0] {StEntryA, StEntryB, StCalc, StConv, StShow, StError} state_e;
    typedef enum logic [1:0] {OpNone, OpAdd, OpSub} op_e;

    localparam logic [15:0] MaxVal   = 16'(MAX_VAL);
    localparam logic [4:0]  ConvLast = 5'(CONV_CYCLES - 1);

    state_e             state_q, state_d;
    op_e                op_q, op_d, next_op_q, next_op_d;
    logic               valid_q;
    logic [15:0]        entry_q, entry_d;
    logic               b_present_q, b_present_d;
    logic signed [15:0] acc_q, acc_d;
    logic [31:0]        disp_q, disp_d;
    logic               sign_q, sign_d;
    logic [15:0]        bcd_q, bcd_d;
    logic [13:0]        bin_q, bin_d;
    logic [4:0]         cnt_q, cnt_d;

    logic               accept, take, is_busy;
    logic               key_digit, key_op, key_eq, key_clr;
    op_e                key_nop;
    logic [15:0]        entry_shift, entry_bin, sum_mag, bcd_adj, bcd_next;
    logic signed [15:0] sum;
    logic               over;

    // Add 3 to every BCD nibble that is 5 or more (double-dabble correction).
    function automatic logic [15:0] dd_adjust(input logic [15:0] v);
        logic [15:0] r;
        r = v;
        for (int i = 0; i < 4; i++) begin
            if (v[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = v[i*4 +: 4] + 4'd3;
        end
        return r;
    endfunction

    // Spread four BCD nibbles into the four display bytes.
    function automatic logic [31:0] to_disp(input logic [15:0] b);
        return {4'h0, b[15:12], 4'h0, b[11:8], 4'h0, b[7:4], 4'h0, b[3:0]};
    endfunction

    // Key decode, edge-detected accept and combinational arithmetic.
    always_comb begin
        is_busy   = (state_q == StCalc) || (state_q == StConv);
        accept    = valid && !valid_q;
        key_digit = key <= 4'd9;
        key_op    = (key == 4'd10) || (key == 4'd11);
        key_eq    = (key >= 4'd12) && (key <= 4'd14);
        key_clr   = key == 4'd15;
        take      = accept && (!is_busy || key_clr);
        key_nop   = (key == 4'd10) ? OpAdd : (key == 4'd11) ? OpSub : OpNone;
        // A digit only shifts in while the top nibble is still free; leading zeros never fill it.
        entry_shift = (entry_q[15:12] == 4'd0) ? {entry_q[11:0], key} : entry_q;
        entry_bin = {12'd0, entry_q[15:12]} * 16'd1000 + {12'd0, entry_q[11:8]} * 16'd100
                  + {12'd0, entry_q[7:4]} * 16'd10 + {12'd0, entry_q[3:0]};
        sum       = (op_q == OpSub) ? acc_q - $signed(entry_bin) : acc_q + $signed(entry_bin);
        sum_mag   = sum[15] ? $unsigned(-sum) : $unsigned(sum);
        over      = sum_mag > MaxVal;
        bcd_adj   = dd_adjust(bcd_q);
        bcd_next  = (bcd_adj << 1) | {15'd0, bin_q[13]};
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= StEntryA;
        else     state_q <= state_d;
    end

    // Next-state logic; clear overrides everything, including a running conversion.
    always_comb begin
        state_d = state_q;
        if (take && key_clr) begin
            state_d = StEntryA;
        end else begin
            unique case (state_q)
                StEntryA: begin
                    if (take && key_op)      state_d = StEntryB;
                    else if (take && key_eq) state_d = StShow;
                end
                StEntryB: begin
                    if (take && (key_op || key_eq)) begin
                        if (b_present_q) state_d = StCalc;
                        else if (key_op) state_d = StEntryB;
                        else             state_d = StShow;
                    end
                end
                StCalc: state_d = over ? StError : StConv;
                StConv: begin
                    if (cnt_q == ConvLast) state_d = (next_op_q != OpNone) ? StEntryB : StShow;
                end
                StShow: begin
                    if (take && key_digit)   state_d = StEntryA;
                    else if (take && key_op) state_d = StEntryB;
                end
                default: ;
            endcase
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q     <= 1'b0;
            entry_q     <= '0;
            b_present_q <= 1'b0;
            acc_q       <= '0;
            op_q        <= OpNone;
            next_op_q   <= OpNone;
            disp_q      <= '0;
            sign_q      <= 1'b0;
            bcd_q       <= '0;
            bin_q       <= '0;
            cnt_q       <= '0;
        end else begin
            valid_q     <= valid;
            entry_q     <= entry_d;
            b_present_q <= b_present_d;
            acc_q       <= acc_d;
            op_q        <= op_d;
            next_op_q   <= next_op_d;
            disp_q      <= disp_d;
            sign_q      <= sign_d;
            bcd_q       <= bcd_d;
            bin_q       <= bin_d;
            cnt_q       <= cnt_d;
        end
    end

    // Datapath next-state: operand entry, accumulate, and BCD conversion.
    always_comb begin
        entry_d     = entry_q;
        b_present_d = b_present_q;
        acc_d       = acc_q;
        op_d        = op_q;
        next_op_d   = next_op_q;
        disp_d      = disp_q;
        sign_d      = sign_q;
        bcd_d       = bcd_q;
        bin_d       = bin_q;
        cnt_d       = cnt_q;
        if (take && key_clr) begin
            entry_d     = '0;
            b_present_d = 1'b0;
            acc_d       = '0;
            op_d        = OpNone;
            next_op_d   = OpNone;
            disp_d      = '0;
            sign_d      = 1'b0;
            bcd_d       = '0;
            bin_d       = '0;
            cnt_d       = '0;
        end else begin
            unique case (state_q)
                StEntryA: begin
                    if (take && key_digit) begin
                        entry_d = entry_shift;
                        disp_d  = to_disp(entry_shift);
                        sign_d  = 1'b0;
                    end else if (take && (key_op || key_eq)) begin
                        acc_d       = $signed(entry_bin);
                        op_d        = key_nop;
                        b_present_d = 1'b0;
                    end
                end
                StEntryB: begin
                    if (take && key_digit) begin
                        // The first B digit replaces whatever the entry register still held.
                        entry_d     = b_present_q ? entry_shift : {12'd0, key};
                        disp_d      = to_disp(b_present_q ? entry_shift : {12'd0, key});
                        sign_d      = 1'b0;
                        b_present_d = 1'b1;
                    end else if (take && (key_op || key_eq)) begin
                        if (b_present_q) next_op_d = key_nop;
                        else             op_d      = key_nop;
                    end
                end
                StCalc: begin
                    acc_d = sum;
                    if (over) begin
                        disp_d = ERROR_CODE;
                        sign_d = 1'b0;
                    end else begin
                        bin_d = sum_mag[13:0];
                        bcd_d = '0;
                        cnt_d = '0;
                    end
                end
                StConv: begin
                    bcd_d = bcd_next;
                    bin_d = {bin_q[12:0], 1'b0};
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == ConvLast) begin
                        disp_d      = to_disp(bcd_next);
                        sign_d      = acc_q[15];
                        op_d        = next_op_q;
                        b_present_d = 1'b0;
                    end
                end
                StShow: begin
                    if (take && key_digit) begin
                        entry_d = {12'd0, key};
                        acc_d   = '0;
                        disp_d  = to_disp({12'd0, key});
                        sign_d  = 1'b0;
                    end else if (take && key_op) begin
                        op_d        = key_nop;
                        b_present_d = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs.
    always_comb begin
        digit1 = disp_q[31:24];
        digit2 = disp_q[23:16];
        digit3 = disp_q[15:8];
        digit4 = disp_q[7:0];
        sign   = sign_q;
        busy   = is_busy;
    end

endmodule

// File: tb/tb_cal_key_engine.sv
// tb_cal_key_engine: random and directed key sequences checked every cycle against a
// value-level calculator model, plus literal expectations for the directed sequences.
module tb_cal_key_engine;

    logic       clk   = 1'b0;
    logic       rst   = 1'b0;
    logic       valid = 1'b0;
    logic [3:0] key   = 4'd0;
    logic [7:0] digit1, digit2, digit3, digit4;
    logic       sign, busy;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    cal_key_engine dut (
        .clk(clk), .rst(rst), .valid(valid), .key(key),
        .digit1(digit1), .digit2(digit2), .digit3(digit3), .digit4(digit4),
        .sign(sign), .busy(busy)
    );

    always #5 clk = ~clk;

    // Model: plain integers, operating mode, and a countdown until the pending result lands.
    localparam int ModeA = 0, ModeB = 1, ModeShow = 2, ModeErr = 3;
    int m_acc = 0, m_entry = 0, m_disp = 0, m_busy = 0, m_mode = ModeA;
    int m_op = 0, m_nop = 0;
    bit m_err = 0, m_sign = 0, m_bpres = 0, m_perr = 0, m_vprev = 0;

    task automatic model_reset();
        m_acc = 0; m_entry = 0; m_disp = 0; m_busy = 0; m_mode = ModeA;
        m_op = 0; m_nop = 0; m_err = 0; m_sign = 0; m_bpres = 0; m_perr = 0;
    endtask

    task automatic show_entry();
        m_disp = m_entry; m_sign = 0; m_err = 0;
    endtask

    task automatic model_key(input int k);
        int nop, r, mag;
        nop = (k == 10) ? 1 : (k == 11) ? 2 : 0;
        case (m_mode)
            ModeA: begin
                if (k <= 9) begin
                    if (m_entry < 1000) m_entry = m_entry * 10 + k;
                    show_entry();
                end else if (k <= 14) begin
                    m_acc = m_entry; m_op = nop; m_bpres = 0;
                    m_mode = (k <= 11) ? ModeB : ModeShow;
                end
            end
            ModeB: begin
                if (k <= 9) begin
                    if (!m_bpres) m_entry = k;
                    else if (m_entry < 1000) m_entry = m_entry * 10 + k;
                    m_bpres = 1;
                    show_entry();
                end else if (k <= 14) begin
                    if (!m_bpres) begin
                        m_op = nop;
                        m_mode = (nop != 0) ? ModeB : ModeShow;
                    end else begin
                        r = (m_op == 2) ? m_acc - m_entry : m_acc + m_entry;
                        mag = (r < 0) ? -r : r;
                        m_acc = r; m_nop = nop;
                        m_perr = mag > 9999;
                        m_busy = m_perr ? 1 : 15;
                    end
                end
            end
            ModeShow: begin
                if (k <= 9) begin
                    m_entry = k; m_acc = 0; m_mode = ModeA;
                    show_entry();
                end else if (k <= 11) begin
                    m_op = nop; m_bpres = 0; m_mode = ModeB;
                end
            end
            default: ;
        endcase
    endtask

    task automatic model_finish();
        if (m_perr) begin
            m_mode = ModeErr; m_err = 1; m_sign = 0;
        end else begin
            m_disp = (m_acc < 0) ? -m_acc : m_acc;
            m_sign = m_acc < 0; m_err = 0;
            m_op = m_nop; m_bpres = 0;
            m_mode = (m_nop != 0) ? ModeB : ModeShow;
        end
    endtask

    function automatic logic [31:0] exp_digits();
        if (m_err) return 32'h00000ABB;
        return {8'(m_disp / 1000 % 10), 8'(m_disp / 100 % 10), 8'(m_disp / 10 % 10),
                8'(m_disp % 10)};
    endfunction

    // Model advance on every clock edge or reset.
    initial forever begin
        bit acc_k;
        @(posedge clk or posedge rst);
        if (rst) begin
            model_reset();
            m_vprev = 0;
        end else begin
            acc_k = valid && !m_vprev;
            m_vprev = valid;
            if (acc_k && key == 4'd15) begin
                model_reset();
            end else if (m_busy > 0) begin
                m_busy--;
                if (m_busy == 0) model_finish();
            end else if (acc_k) begin
                model_key(int'(key));
            end
        end
    end

    // Per-cycle compare against the model.
    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            n_tests++;
            if ({digit1, digit2, digit3, digit4} !== exp_digits() || sign !== m_sign
                || busy !== (m_busy > 0)) begin
                n_fail++;
                $display("FAIL cycle t=%0t: got digits=%h sign=%b busy=%b, want digits=%h sign=%b busy=%b",
                         $time, {digit1, digit2, digit3, digit4}, sign, busy, exp_digits(),
                         m_sign, (m_busy > 0));
            end
        end
    end

    task automatic check_lit(input string name, input logic [31:0] exp_d, input logic exp_s);
        n_tests++;
        if ({digit1, digit2, digit3, digit4} !== exp_d || sign !== exp_s) begin
            n_fail++;
            $display("FAIL %s: got digits=%h sign=%b, want digits=%h sign=%b", name,
                     {digit1, digit2, digit3, digit4}, sign, exp_d, exp_s);
        end
        n_tests++;
        if (exp_digits() !== exp_d || m_sign !== exp_s) begin
            n_fail++;
            $display("FAIL %s_model: model digits=%h sign=%b, want digits=%h sign=%b", name,
                     exp_digits(), m_sign, exp_d, exp_s);
        end
    endtask

    task automatic check_busy(input string name, input logic exp_b);
        n_tests++;
        if (busy !== exp_b) begin
            n_fail++;
            $display("FAIL %s: got busy=%b, want busy=%b", name, busy, exp_b);
        end
    endtask

    task automatic press(input int k, input int hold, input int gap);
        @(negedge clk);
        valid = 1'b1;
        key   = 4'(k);
        repeat (hold) @(negedge clk);
        valid = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic k(input int v);
        press(v, 10, 10);
    endtask

    initial begin
        #1 rst = 1'b1;
        @(negedge clk);
        check_lit("reset", 32'h0, 1'b0);
        check_busy("reset_busy", 1'b0);
        #2 rst = 1'b0;
        chk_en = 1'b1;

        // 12 + 34 + -> 46, then 4 = -> 50
        k(15); k(1); k(2); k(10); k(3); k(4); k(10);
        check_lit("add_chain", 32'h00000406, 1'b0);
        k(4); k(12);
        check_lit("add_chain_eq", 32'h00000500, 1'b0);

        // 5 - 123 = -> -118, then + 200 = -> 82
        k(15); k(5); k(11); k(1); k(2); k(3); k(12);
        check_lit("sub_negative", 32'h00010108, 1'b1);
        k(10); k(2); k(0); k(0); k(12);
        check_lit("chain_from_neg", 32'h00000802, 1'b0);

        // 9999 + 1 + -> overflow error; digits ignored; clear exits
        k(15); k(9); k(9); k(9); k(9); k(10); k(1); k(10);
        check_lit("overflow", 32'h00000ABB, 1'b0);
        k(7);
        check_lit("error_sticky", 32'h00000ABB, 1'b0);
        k(15);
        check_lit("clear_from_error", 32'h0, 1'b0);

        // Fifth digit ignored; long hold accepted once
        k(1); k(2); k(3); k(4); k(5);
        check_lit("five_digits", 32'h01020304, 1'b0);
        press(6, 30, 10);
        check_lit("full_hold", 32'h01020304, 1'b0);
        k(15); press(6, 30, 10);
        check_lit("hold_once", 32'h00000006, 1'b0);

        // Operator replacement, digit dropped while busy, zero result has no sign
        k(15); k(8); k(10); k(11); k(3);
        press(12, 2, 2);
        press(4, 2, 20);
        check_lit("op_replace_drop", 32'h00000005, 1'b0);
        k(11); k(5); k(12);
        check_lit("zero_result", 32'h0, 1'b0);

        // Reset in the middle of a conversion
        k(15); k(7); k(10); k(2);
        @(negedge clk);
        valid = 1'b1; key = 4'd10;
        repeat (2) @(negedge clk);
        valid = 1'b0;
        repeat (4) @(negedge clk);
        check_busy("busy_mid_conv", 1'b1);
        #2 rst = 1'b1;
        #1;
        check_lit("rst_abort", 32'h0, 1'b0);
        check_busy("rst_abort_busy", 1'b0);
        @(negedge clk);
        #2 rst = 1'b0;
        k(3); k(12);
        check_lit("after_rst", 32'h00000003, 1'b0);

        // Random key traffic with random hold and gap, including presses during busy
        k(15);
        for (int i = 0; i < 200; i++) begin
            int r, kk;
            r = int'($urandom_range(99));
            if (r < 55)      kk = int'($urandom_range(9));
            else if (r < 75) kk = 10 + int'($urandom_range(1));
            else if (r < 96) kk = 12 + int'($urandom_range(2));
            else             kk = 15;
            if (m_mode == ModeErr && $urandom_range(3) == 0) kk = 15;
            press(kk, int'($urandom_range(12, 2)), int'($urandom_range(20, 1)));
        end

        repeat (20) @(negedge clk);
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
